// File: rtl/piece_queue.sv
// piece_queue
//   Buffers upcoming tetromino IDs between the random number generator and
//   the game-control FSM. Each cycle the generator word is sampled; values
//   outside 0..NUM_PIECES-1 are discarded, one immediate repeat may be
//   rerolled, and accepted IDs are pushed into a DEPTH-entry FIFO. A spawn
//   request pops the head and presents it with a one-cycle valid strobe.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   rand_data    32-bit generator output, sampled every cycle
//   spawn_req    request for the next piece (one cycle = one request)
//   spawn_valid  one-cycle strobe, spawn_piece valid while high
//   spawn_piece  popped piece ID (holds last value otherwise)
//   next_piece   FIFO head for preview, 0 when empty
//   next_valid   FIFO non-empty
//   count        FIFO occupancy, 0..DEPTH
//   full         count == DEPTH
module piece_queue #(
    parameter int DEPTH      = 4,
    parameter int NUM_PIECES = 5,
    parameter int REROLL     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rand_data,
    input  logic        spawn_req,
    output logic        spawn_valid,
    output logic [2:0]  spawn_piece,
    output logic [2:0]  next_piece,
    output logic        next_valid,
    output logic [3:0]  count,
    output logic        full
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [3:0]  DEPTH_C = 4'(DEPTH);
    localparam logic [31:0] NUM_C   = 32'(NUM_PIECES);
    localparam logic [2:0]  NONE    = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE
    } state_e;

    state_e         state_q, state_d;
    logic [2:0]     mem_q [DEPTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [3:0]     count_q, count_d;
    logic [2:0]     last_q, last_d;
    logic           used_q, used_d;
    logic [2:0]     spawn_q, spawn_d;

    logic [2:0]     cand;
    logic           in_range;
    logic           room;
    logic           reroll;
    logic           push;
    logic           pop;

    // Spawn FSM: pop decision and next state
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE, S_ISSUE: begin
                if (spawn_req) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // spawn_req ignored here: one outstanding request at most
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Candidate filtering and FIFO bookkeeping
    always_comb begin
        cand     = rand_data[2:0];
        in_range = (rand_data < NUM_C);
        // A pop in the same cycle frees the slot the push will use
        room     = (count_q < DEPTH_C) || pop;
        // A candidate that could not be stored has no side effects, so the
        // reroll is only consumed when there is room for the candidate
        reroll   = (REROLL != 0) && in_range && room &&
                   (cand == last_q) && !used_q;
        push     = in_range && room && !reroll;

        head_d   = pop  ? head_q + PW'(1) : head_q;
        tail_d   = push ? tail_q + PW'(1) : tail_q;

        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 4'd1;
        end else if (pop && !push) begin
            count_d = count_q - 4'd1;
        end

        last_d   = push ? cand : last_q;
        used_d   = used_q;
        if (push) begin
            used_d = 1'b0;
        end else if (reroll) begin
            used_d = 1'b1;
        end

        spawn_d  = pop ? mem_q[head_q] : spawn_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            last_q  <= NONE;
            used_q  <= 1'b0;
            spawn_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            last_q  <= last_d;
            used_q  <= used_d;
            spawn_q <= spawn_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    // When full, tail == head: the pop reads the old entry before overwrite.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= cand;
        end
    end

    assign spawn_valid = (state_q == S_ISSUE);
    assign spawn_piece = spawn_q;
    assign next_valid  = (count_q != '0);
    assign next_piece  = next_valid ? mem_q[head_q] : 3'd0;
    assign count       = count_q;
    assign full        = (count_q == DEPTH_C);

endmodule

// File: tb/tb_piece_queue.sv
// tb_piece_queue
//   Directed bench for piece_queue. A queue-based model of the piece buffer
//   and request handling is compared against the DUT every cycle; literal
//   expectations at key points pin the model.
module tb_piece_queue;

    localparam int DEPTH      = 4;
    localparam int NUM_PIECES = 5;
    localparam int REROLL     = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rand_data = 32'd9;
    logic        spawn_req = 1'b0;
    logic        spawn_valid;
    logic [2:0]  spawn_piece;
    logic [2:0]  next_piece;
    logic        next_valid;
    logic [3:0]  count;
    logic        full;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    piece_queue #(
        .DEPTH      (DEPTH),
        .NUM_PIECES (NUM_PIECES),
        .REROLL     (REROLL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rand_data   (rand_data),
        .spawn_req   (spawn_req),
        .spawn_valid (spawn_valid),
        .spawn_piece (spawn_piece),
        .next_piece  (next_piece),
        .next_valid  (next_valid),
        .count       (count),
        .full        (full)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    int m_q[$];
    int m_last    = 7;
    bit m_used    = 1'b0;
    bit m_waiting = 1'b0;
    bit m_valid   = 1'b0;
    int m_piece   = 0;

    task automatic model_step();
        int  sz;
        bit  want;
        bit  popped;
        int  c;
        if (reset) begin
            m_q.delete();
            m_last    = 7;
            m_used    = 1'b0;
            m_waiting = 1'b0;
            m_valid   = 1'b0;
            m_piece   = 0;
        end else begin
            sz      = m_q.size();
            want    = m_waiting || spawn_req;
            popped  = 1'b0;
            m_valid = 1'b0;
            if (want && sz > 0) begin
                m_piece   = m_q.pop_front();
                m_valid   = 1'b1;
                popped    = 1'b1;
                m_waiting = 1'b0;
            end else begin
                m_waiting = want;
            end
            c = int'(rand_data[2:0]);
            if (rand_data < 32'(NUM_PIECES) && (sz < DEPTH || popped)) begin
                if (REROLL != 0 && c == m_last && !m_used) begin
                    m_used = 1'b1;
                end else begin
                    m_q.push_back(c);
                    m_last = c;
                    m_used = 1'b0;
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model.count", int'(count), m_q.size());
            chk("model.full", int'(full), int'(m_q.size() == DEPTH));
            chk("model.next_valid", int'(next_valid), int'(m_q.size() != 0));
            chk("model.next_piece", int'(next_piece), (m_q.size() != 0) ? m_q[0] : 0);
            chk("model.spawn_valid", int'(spawn_valid), int'(m_valid));
            chk("model.spawn_piece", int'(spawn_piece), m_piece);
        end
    end

    // Drive inputs at a falling edge; return at the next falling edge
    task automatic cyc(input logic [31:0] rd, input logic req);
        rand_data = rd;
        spawn_req = req;
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".count"}, int'(count), 0);
        chk({tag, ".full"}, int'(full), 0);
        chk({tag, ".next_valid"}, int'(next_valid), 0);
        chk({tag, ".next_piece"}, int'(next_piece), 0);
        chk({tag, ".spawn_valid"}, int'(spawn_valid), 0);
        chk({tag, ".spawn_piece"}, int'(spawn_piece), 0);
    endtask

    int exp_cnt[5]  = '{1, 2, 3, 4, 4};
    int fill_in[5]  = '{2, 3, 4, 1, 0};
    int fill_out[4] = '{2, 3, 4, 1};
    int rr_in[6]    = '{1, 1, 1, 9, 7, 3};
    int rr_out[3]   = '{1, 1, 3};
    int fs_out[4]   = '{1, 2, 3, 4};

    initial begin
        // Reset
        reset = 1'b1;
        @(negedge clk);
        cyc(32'd9, 1'b0);
        reset = 1'b0;
        chk_zero("reset");
        chk_en = 1'b1;

        // Fill after reset
        for (int i = 0; i < 5; i++) begin
            cyc(32'(fill_in[i]), 1'b0);
            chk("fill.count", int'(count), exp_cnt[i]);
            chk("fill.full", int'(full), int'(i >= 3));
        end
        chk("fill.next_piece", int'(next_piece), 2);

        // Back-to-back spawn
        for (int i = 0; i < 4; i++) begin
            cyc(32'd9, 1'b1);
            chk("b2b.spawn_valid", int'(spawn_valid), 1);
            chk("b2b.spawn_piece", int'(spawn_piece), fill_out[i]);
        end
        chk("b2b.count", int'(count), 0);
        chk("b2b.next_valid", int'(next_valid), 0);
        cyc(32'd9, 1'b0);
        chk("b2b.idle_valid", int'(spawn_valid), 0);

        // Range and reroll from a fresh reset
        reset = 1'b1;
        cyc(32'd9, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) cyc(32'(rr_in[i]), 1'b0);
        chk("rr.count", int'(count), 3);
        for (int i = 0; i < 3; i++) begin
            cyc(32'd9, 1'b1);
            chk("rr.spawn_piece", int'(spawn_piece), rr_out[i]);
        end
        cyc(32'd9, 1'b0);

        // Empty request: waits until the first push
        cyc(32'd9, 1'b1);
        chk("empty.req_valid", int'(spawn_valid), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(32'd9, 1'b0);
            chk("empty.wait_valid", int'(spawn_valid), 0);
        end
        cyc(32'd4, 1'b0);
        chk("empty.push_valid", int'(spawn_valid), 0);
        chk("empty.push_count", int'(count), 1);
        cyc(32'd9, 1'b0);
        chk("empty.spawn_valid", int'(spawn_valid), 1);
        chk("empty.spawn_piece", int'(spawn_piece), 4);
        cyc(32'd9, 1'b0);
        chk("empty.after_valid", int'(spawn_valid), 0);

        // Full with simultaneous pop and push
        for (int i = 0; i < 4; i++) cyc(32'(i), 1'b0);
        chk("fullpp.pre_full", int'(full), 1);
        cyc(32'd4, 1'b1);
        chk("fullpp.spawn_piece", int'(spawn_piece), 0);
        chk("fullpp.count", int'(count), 4);
        for (int i = 0; i < 4; i++) begin
            cyc(32'd9, 1'b1);
            chk("fullpp.drain", int'(spawn_piece), fs_out[i]);
        end
        cyc(32'd9, 1'b0);

        // Pop and push with a single entry
        cyc(32'd2, 1'b0);
        cyc(32'd3, 1'b1);
        chk("one.spawn_piece", int'(spawn_piece), 2);
        chk("one.next_piece", int'(next_piece), 3);
        chk("one.count", int'(count), 1);
        cyc(32'd9, 1'b1);
        cyc(32'd9, 1'b0);

        // Reset while waiting, with a candidate arriving at the reset edge
        cyc(32'd9, 1'b1);
        cyc(32'd9, 1'b0);
        reset = 1'b1;
        cyc(32'd1, 1'b0);
        reset = 1'b0;
        chk_zero("rstwait");
        cyc(32'd9, 1'b0);
        cyc(32'd2, 1'b0);
        chk("rstwait.no_spawn", int'(spawn_valid), 0);
        chk("rstwait.count", int'(count), 1);

        // Reset with two queued pieces and a concurrent request
        cyc(32'd1, 1'b0);
        chk("rst2.count", int'(count), 2);
        reset = 1'b1;
        cyc(32'd3, 1'b1);
        reset = 1'b0;
        chk_zero("rst2");
        for (int i = 0; i < 3; i++) begin
            cyc(32'd9, 1'b0);
            chk("rst2.no_spawn", int'(spawn_valid), 0);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
